// File: rtl/clk_lock_monitor.sv
// ---------------------------------------------------------------------------
// clk_lock_monitor
//   Measures the period of the divider output (clk_mon, sampled as data) in
//   inclk0 cycles and reports lock after LOCK_COUNT consecutive good periods.
//   A wrong period or a missing edge drops lock and pulses lost for one cycle.
//   The locked output gates processor reset release.
//
// Ports
//   inclk0       in   reference clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   enable       in   monitor enable, low forces IDLE
//   clk_mon      in   monitored clock (divider c0)
//   locked       out  high while in LOCKED
//   lost         out  one-cycle pulse on LOCKED -> LOST
//   last_period  out  last measured period in inclk0 cycles (saturating)
//   err_count    out  number of lock losses (saturating at 255)
//
// Build option
//   CLK_MON_ERRCNT_EN : when defined, err_count counts LOST entries;
//                       otherwise err_count is tied to zero.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | monitor disabled; counters and qualification cleared
// ACQUIRE | counting consecutive good periods toward lock
// LOCKED  | locked=1; any bad period or timeout leaves
// LOST    | one cycle; lost=1, then back to ACQUIRE (or IDLE)
// ---------------------------------------------------------------------------
module clk_lock_monitor #(
  parameter int DIV_RATIO  = 2,
  parameter int LOCK_COUNT = 8,
  parameter int TOL        = 0,
  parameter int CNT_W      = 8
) (
  input  logic             inclk0,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clk_mon,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] last_period,
  output logic [7:0]       err_count
);

  localparam int GOOD_W  = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int P_MIN_I = (DIV_RATIO > TOL) ? (DIV_RATIO - TOL) : 0;
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(P_MIN_I);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(DIV_RATIO + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period;
  logic [GOOD_W-1:0]  good;
  logic               first;
  logic               seen;
  logic               edge_det;
  logic               period_ok;
  logic               timeout;
  logic               bad_evt;

  assign edge_det  = s2 & ~s3;
  assign period    = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign period_ok = (period >= P_MIN) && (period <= P_MAX);
  // An edge arriving on the threshold cycle wins over the timeout.
  assign timeout   = ~edge_det && (cnt >= P_MAX);
  assign bad_evt   = (edge_det && !period_ok) || timeout;

  // Two-flop synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_mon;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Period counter and last_period capture. seen marks that an edge has
  // been observed since leaving IDLE, so cnt then spans a real period even
  // if a timeout has reset lock qualification in between.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_period <= '0;
      seen        <= 1'b0;
    end else if (!enable || state == IDLE) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (edge_det) begin
      cnt  <= '0;
      seen <= 1'b1;
      if (seen) last_period <= period;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      locked <= 1'b0;
      lost   <= 1'b0;
      good   <= '0;
      first  <= 1'b1;
    end else if (!enable) begin
      state  <= IDLE;
      locked <= 1'b0;
      lost   <= 1'b0;
      good   <= '0;
      first  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state  <= ACQUIRE;
          locked <= 1'b0;
          lost   <= 1'b0;
          good   <= '0;
          first  <= 1'b1;
        end
        ACQUIRE: begin
          lost <= 1'b0;
          if (edge_det && first) begin
            first <= 1'b0;
          end else if (edge_det && period_ok) begin
            if (good == GOOD_LAST) begin
              good   <= GOOD_FULL;
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              good <= good + 1'b1;
            end
          end else if (bad_evt) begin
            good  <= '0;
            first <= 1'b1;
          end
        end
        LOCKED: begin
          if (bad_evt) begin
            state  <= LOST;
            locked <= 1'b0;
            lost   <= 1'b1;
            good   <= '0;
            first  <= 1'b1;
          end
        end
        LOST: begin
          state  <= ACQUIRE;
          locked <= 1'b0;
          lost   <= 1'b0;
          good   <= '0;
          first  <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          lost   <= 1'b0;
          good   <= '0;
          first  <= 1'b1;
        end
      endcase
    end
  end

`ifdef CLK_MON_ERRCNT_EN
  logic lose_lock;

  // Same condition that moves LOCKED -> LOST; enable=0 suppresses it.
  assign lose_lock = enable && (state == LOCKED) && bad_evt;

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (lose_lock && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule
